// File: rtl/mlp_engine.sv
// Two-layer fixed-point perceptron classifier: ROM sample -> ReLU hidden layer -> output layer -> argmax.
// Define MLP_ACT_SAT_EN to saturate the hidden activation at 255 instead of keeping its low 8 bits.
module mlp_engine #(
  parameter int N_IN      = 62,
  parameter int N_HID     = 30,
  parameter int N_OUT     = 10,
  parameter int N_SAMPLES = 750,
  parameter int ACT_SHIFT = 8,
  parameter     DATA_FILE = "data.hex",
  parameter     W1_FILE   = "w1.hex",
  parameter     B1_FILE   = "b1.hex",
  parameter     W2_FILE   = "w2.hex",
  parameter     B2_FILE   = "b2.hex"
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [9:0] test_num,
  output logic [3:0] out,
  output logic       done
);

  localparam int DEPTH = 1024;
  localparam int DA    = $clog2(DEPTH * N_IN);
  localparam int W1A   = $clog2(N_HID * N_IN);
  localparam int W2A   = $clog2(N_OUT * N_HID);
  localparam int HA    = $clog2(N_HID);
  localparam int OA    = $clog2(N_OUT);
  localparam int IW    = 8;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_L1, S_ACT, S_L2, S_ARG, S_DONE} state_t;

  logic signed [7:0]  data_rom [DEPTH*N_IN];
  logic signed [7:0]  w1_rom   [N_HID*N_IN];
  logic signed [15:0] b1_rom   [N_HID];
  logic signed [7:0]  w2_rom   [N_OUT*N_HID];
  logic signed [15:0] b2_rom   [N_OUT];

  state_t             state_q, state_d;
  logic [IW-1:0]      idx_q, idx_d;
  logic [9:0]         tn_q;
  logic signed [23:0] acc1_q [N_HID];
  logic signed [23:0] acc2_q [N_OUT];
  logic [7:0]         h_q    [N_HID];
  logic signed [23:0] best_val_q;
  logic [3:0]         best_idx_q;
  logic [3:0]         out_q;
  logic               done_q;
  logic               accept;

  logic [DA-1:0]      daddr;
  logic signed [7:0]  x_cur;
  logic [HA-1:0]      idx_l2;
  logic [OA-1:0]      arg_sel;
  logic signed [23:0] acc2_sel;
  logic               better;
  logic signed [23:0] prod1 [N_HID];
  logic signed [23:0] prod2 [N_OUT];

  function automatic logic [7:0] relu_act(input logic signed [23:0] a);
    logic signed [23:0] s;
    s = a >>> ACT_SHIFT;
    if (s < 0) return 8'd0;
`ifdef MLP_ACT_SAT_EN
    if (s > 24'sd255) return 8'hFF;
`endif
    return s[7:0];
  endfunction

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: if (start) begin state_d = S_LOAD; accept = 1'b1; end
      S_LOAD:         state_d = S_L1;
      S_L1:           if (idx_q == IW'(N_IN - 1))  state_d = S_ACT;
      S_ACT:          state_d = S_L2;
      S_L2:           if (idx_q == IW'(N_HID - 1)) state_d = S_ARG;
      S_ARG:          if (idx_q == IW'(N_OUT - 1)) state_d = S_DONE;
      default:        state_d = S_IDLE;
    endcase
    idx_d = '0;
    if (state_d == state_q && (state_q == S_L1 || state_q == S_L2 || state_q == S_ARG))
      idx_d = idx_q + IW'(1);
  end

  // Samples beyond N_SAMPLES read as zero, leaving only the bias contribution.
  always_comb begin
    daddr    = DA'(tn_q) * DA'(N_IN) + DA'(idx_q);
    x_cur    = (int'(tn_q) < N_SAMPLES) ? data_rom[daddr] : 8'sd0;
    idx_l2   = (state_q == S_L2)  ? HA'(idx_q) : '0;
    arg_sel  = (state_q == S_ARG) ? OA'(idx_q) : '0;
    acc2_sel = acc2_q[arg_sel];
    better   = (idx_q == '0) || (acc2_sel > best_val_q);
  end

  always_comb begin : p_mul
    logic signed [15:0] p1;
    logic signed [16:0] p2;
    logic signed [8:0]  hz;
    p1 = '0;
    p2 = '0;
    hz = $signed({1'b0, h_q[idx_l2]});
    for (int j = 0; j < N_HID; j++) begin
      p1       = x_cur * w1_rom[W1A'(j * N_IN) + W1A'(idx_q)];
      prod1[j] = 24'(p1);
    end
    for (int k = 0; k < N_OUT; k++) begin
      p2       = hz * w2_rom[W2A'(k * N_HID) + W2A'(idx_l2)];
      prod2[k] = 24'(p2);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      tn_q       <= '0;
      best_val_q <= '0;
      best_idx_q <= '0;
      out_q      <= '0;
      done_q     <= 1'b0;
      for (int j = 0; j < N_HID; j++) begin
        acc1_q[j] <= '0;
        h_q[j]    <= '0;
      end
      for (int k = 0; k < N_OUT; k++) acc2_q[k] <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      case (state_q)
        S_IDLE, S_DONE: if (accept) begin
          tn_q   <= test_num;
          done_q <= 1'b0;
        end
        S_LOAD: begin
          for (int j = 0; j < N_HID; j++) acc1_q[j] <= 24'(b1_rom[j]);
          for (int k = 0; k < N_OUT; k++) acc2_q[k] <= 24'(b2_rom[k]);
        end
        S_L1:  for (int j = 0; j < N_HID; j++) acc1_q[j] <= acc1_q[j] + prod1[j];
        S_ACT: for (int j = 0; j < N_HID; j++) h_q[j] <= relu_act(acc1_q[j]);
        S_L2:  for (int k = 0; k < N_OUT; k++) acc2_q[k] <= acc2_q[k] + prod2[k];
        S_ARG: begin
          // Strict greater-than keeps the lowest index on ties.
          if (better) begin
            best_val_q <= acc2_sel;
            best_idx_q <= 4'(idx_q);
          end
          if (idx_q == IW'(N_OUT - 1)) begin
            out_q  <= better ? 4'(idx_q) : best_idx_q;
            done_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign out  = out_q;
  assign done = done_q;

endmodule

// File: tb/tb_mlp_engine.sv
// Directed bench for mlp_engine; ROMs are filled directly with hand-built vectors.
module tb_mlp_engine;
  localparam int N_IN  = 62;
  localparam int N_HID = 30;
  localparam int N_OUT = 10;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [9:0] test_num = '0;
  logic [3:0] out;
  logic       done;

  int tests = 0;
  int fails = 0;
  int cyc;
  int ndone;

  always #5 clk = ~clk;

  mlp_engine #(
    .ACT_SHIFT(0),
    .DATA_FILE(""), .W1_FILE(""), .B1_FILE(""), .W2_FILE(""), .B2_FILE("")
  ) dut (
    .clk(clk), .rst(rst), .start(start), .test_num(test_num), .out(out), .done(done)
  );

  task automatic check(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_weights();
    for (int i = 0; i < N_HID*N_IN; i++) dut.w1_rom[i] = 8'sd0;
    for (int i = 0; i < N_OUT*N_HID; i++) dut.w2_rom[i] = 8'sd0;
    for (int i = 0; i < N_HID; i++) dut.b1_rom[i] = 16'sd0;
    for (int i = 0; i < N_OUT; i++) dut.b2_rom[i] = 16'sd0;
  endtask

  task automatic set_w1(input int v);
    for (int i = 0; i < N_HID*N_IN; i++) dut.w1_rom[i] = 8'(v);
  endtask

  task automatic set_sample(input int s, input int v);
    for (int i = 0; i < N_IN; i++) dut.data_rom[s*N_IN + i] = 8'(v);
  endtask

  task automatic wait_done(output int c);
    c = 0;
    while (done !== 1'b1 && c < 200) begin
      @(posedge clk); #1;
      c++;
    end
  endtask

  task automatic run(input int tn, output int c);
    @(negedge clk);
    test_num = 10'(tn);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(c);
    $display("[TB] run test_num=%0d out=%0d done_after=%0d", tn, out, c);
  endtask

  initial begin
    for (int i = 0; i < 1024*N_IN; i++) dut.data_rom[i] = 8'sd0;
    clear_weights();

    repeat (3) @(posedge clk);
    #1;
    check("reset_out", int'(out), 0);
    check("reset_done", int'(done), 0);
    @(negedge clk) rst = 1'b1;

    // Bias-only: class 7 wins on bias alone
    dut.b2_rom[7] = 16'sd100;
    run(5, cyc);
    check("bias_latency", cyc, 104);
    check("bias_out", int'(out), 7);
    check("bias_done", int'(done), 1);
    repeat (20) @(posedge clk);
    #1;
    check("hold_done", int'(done), 1);
    check("hold_out", int'(out), 7);

    // Tie between classes 2 and 6 resolves to 2
    dut.b2_rom[7] = 16'sd0;
    dut.b2_rom[2] = 16'sd50;
    dut.b2_rom[6] = 16'sd50;
    run(0, cyc);
    check("tie_out", int'(out), 2);
    check("tie_latency", cyc, 104);

    // Known vector: x=1, W1=1 -> h=62, W2[k][*]=k -> class 9
    clear_weights();
    set_sample(3, 1);
    set_w1(1);
    for (int k = 0; k < N_OUT; k++)
      for (int i = 0; i < N_HID; i++) dut.w2_rom[k*N_HID + i] = 8'(k);
    run(3, cyc);
    check("known_out", int'(out), 9);
    check("known_h0", int'(dut.h_q[0]), 62);
    check("known_hlast", int'(dut.h_q[N_HID-1]), 62);

    // acc1 = 310: wraps to 54, or saturates to 255
    set_w1(5);
    run(3, cyc);
`ifdef MLP_ACT_SAT_EN
    check("act_h", int'(dut.h_q[5]), 255);
`else
    check("act_h", int'(dut.h_q[5]), 54);
`endif
    check("act_out", int'(out), 9);

    // Negative hidden sums clamp to zero, leaving all outputs tied at 0
    set_w1(-1);
    run(3, cyc);
    check("relu_h", int'(dut.h_q[0]), 0);
    check("relu_out", int'(out), 0);

    // Only class 4 has positive weights
    set_w1(1);
    for (int k = 0; k < N_OUT; k++)
      for (int i = 0; i < N_HID; i++) dut.w2_rom[k*N_HID + i] = (k == 4) ? 8'sd1 : -8'sd1;
    run(3, cyc);
    check("select_out", int'(out), 4);

    // Reset in the middle of L1
    @(negedge clk);
    test_num = 10'd3;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (30) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    check("midrst_out", int'(out), 0);
    check("midrst_done", int'(done), 0);
    @(negedge clk) rst = 1'b1;
    run(3, cyc);
    check("after_rst_out", int'(out), 4);
    check("after_rst_latency", cyc, 104);

    // Start pulse during L2 must not restart the run
    @(negedge clk);
    test_num = 10'd3;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0;
    while (done !== 1'b1 && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
      start = (cyc == 80);
    end
    start = 1'b0;
    $display("[TB] run test_num=3 with L2 start pulse out=%0d done_after=%0d", out, cyc);
    check("l2pulse_latency", cyc, 104);
    check("l2pulse_out", int'(out), 4);
    repeat (10) @(posedge clk);
    #1;
    check("done_sticky", int'(done), 1);

    // Start held high for 300 cycles: back-to-back runs, one done cycle each
    @(negedge clk);
    test_num = 10'd3;
    start = 1'b1;
    ndone = 0;
    for (int c = 0; c < 300; c++) begin
      @(posedge clk); #1;
      if (c == 0) begin
        check("restart_done_drop", int'(done), 0);
        check("restart_out_hold", int'(out), 4);
      end
      if (done === 1'b1) ndone++;
    end
    start = 1'b0;
    $display("[TB] held start: done cycles=%0d", ndone);
    check("held_done_count", ndone, 2);
    wait_done(cyc);
    check("held_final_done", int'(done), 1);
    check("held_final_out", int'(out), 4);

    // Out-of-range sample: data ignored, only biases count
    for (int k = 0; k < N_OUT; k++)
      for (int i = 0; i < N_HID; i++) dut.w2_rom[k*N_HID + i] = 8'(k);
    dut.b2_rom[7] = 16'sd100;
    set_sample(800, 1);
    run(800, cyc);
    check("range_out", int'(out), 7);
    check("range_latency", cyc, 104);
    run(3, cyc);
    check("inrange_out", int'(out), 9);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/mlp_engine.md
Name: mlp_engine

Overview:
- Fixed-point two-layer perceptron classifier. Given a sample index, it reads that sample's feature vector from an internal ROM and runs hidden layer (ReLU) then output layer, followed by argmax, producing a 4-bit class label 0..9.
- Sits beside a label ROM in the classification subsystem; a controller pulses start, waits for done, and compares out against the stored label.

Parameters:
- N_IN, 62, features per sample
- N_HID, 30, hidden neurons
- N_OUT, 10, output classes (≤16)
- N_SAMPLES, 750, valid samples in data ROM; ROM depth fixed at 1024
- ACT_SHIFT, 8, arithmetic right shift applied to hidden accumulator before 8-bit activation
- DATA_FILE / W1_FILE / B1_FILE / W2_FILE / B2_FILE, "data.hex"/"w1.hex"/"b1.hex"/"w2.hex"/"b2.hex", $readmemh init files

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous active-low reset (0 = reset)
- start  in  1  launch request, sampled in IDLE
- test_num  in  10  sample index, latched on accepted start
- out  out  4  predicted class
- done  out  1  result valid

Behaviour:
- Reset (async, rst=0): state IDLE, out=0, done=0, accumulators cleared. Reset mid-run aborts immediately; no partial result kept.
- Arithmetic: features and weights are 8-bit signed; biases 16-bit signed; accumulators 24-bit signed, wrap on overflow.
- Hidden activation: h = max(0, acc1 >>> ACT_SHIFT), truncated to low 8 bits as unsigned 0..255 (see optional feature).
- FSM states:
  - IDLE: start=1 at an edge latches test_num, clears done, goes to LOAD. start while not IDLE/DONE is ignored.
  - LOAD (1 cycle): acc1[j]=B1[j], acc2[k]=B2[k], i=0.
  - L1 (N_IN cycles): all N_HID neurons in parallel: acc1[j] += X[test_num][i]*W1[j][i]; i++.
  - ACT (1 cycle): compute h[j]; i=0.
  - L2 (N_HID cycles): all N_OUT neurons in parallel: acc2[k] += h[i]*W2[k][i], with h zero-extended to 9-bit signed.
  - ARG (N_OUT cycles): sequential argmax over acc2. Strict greater-than, so a tie resolves to the lowest index.
  - DONE: out=argmax, done=1; hold both until the next accepted start or reset.
- From DONE, start=1 behaves as in IDLE: done drops next edge, out holds its old value until the new result.
- Latency: done rises at the edge 1+N_IN+1+N_HID+N_OUT = 104 edges after the start-sampling edge (defaults). It must stay ≤160 cycles for any parameter set used.
- ROMs are combinational-read arrays. Data ROM addressed {test_num, i}-style flat index test_num*N_IN+i.
- Data entries for test_num ≥ N_SAMPLES read as 0, so the result depends on biases only; no error flag.
- start held high across many cycles triggers exactly one run per IDLE/DONE visit.

Optional Feature:
- MLP_ACT_SAT_EN defined: hidden activation saturates to 255 when the shifted accumulator exceeds 255 (still 0 when negative).
- Not defined: low 8 bits kept (wrap), as above.

Test Plan:
- Reset: rst=0 during run mid-L1 -> out=0, done=0 immediately; after rst=1 and start, run completes normally.
- Bias-only: all W1/W2/data=0, B2[7]=100, others 0, start with test_num=5 -> done at exactly 104 cycles, out=7.
- Tie: W=0, B2[2]=B2[6]=50, others 0 -> out=2.
- Known vector: data[3] all 1, W1 all 1, B1=0, ACT_SHIFT=0, W2[k][*]=k, B2=0 -> h=62 each, out=9. With W1 all 5 -> acc1=310, h=54 (wrap) without MLP_ACT_SAT_EN, h=255 with it; out=9 in both cases.
- Handshake: start pulses during L2 ignored; done stays high until the next start; start held high 300 cycles -> runs back-to-back with one done pulse per run.
- Range: test_num=800 with nonzero data ROM -> bias-only result, done at 104 cycles.
